// File: rtl/systolic_result_drain_pkg.sv
// Shared constants and types for the systolic result drain stage.
package systolic_result_drain_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int SIZE_DEF      = 4;
  localparam int IDXW          = $clog2(SIZE_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Valid/ready result stream from the drain stage toward the output FIFO/bus adapter.
interface systolic_result_drain_if
  import systolic_result_drain_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int IW        = IDXW
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_drain_idx_counter.sv
// Row-major (row, col) walker over a Qe x Ke region; reusable by an upstream loader.
module systolic_drain_idx_counter #(
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic [IW:0]   qe,
  input  logic [IW:0]   ke,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam int CW = IW + 1;

  logic row_end;
  logic col_end;

  assign row_end = ({1'b0, row} == (qe - CW'(1)));
  assign col_end = ({1'b0, col} == (ke - CW'(1)));
  assign last    = row_end && col_end;

  // load wins over advance so a new job restarts at (0,0) even on the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row + IW'(1);
      end else begin
        col <= col + IW'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the array result matrix on done and streams the valid QxK region row-major.
//   state | meaning
//   IDLE  | no job held; waiting for done_in
//   DRAIN | snapshot held; presenting buf[row][col] on the stream
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int SIZE      = SIZE_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          done_in,
  input  logic [$clog2(SIZE):0]         depth_A,
  input  logic [$clog2(SIZE):0]         width_B,
  input  logic [SIZE*SIZE*DATAWIDTH-1:0] dout_flat,
  systolic_result_drain_if.master       out_if,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;
  localparam int XW = 2 * IW;

  state_t               state, state_nxt;
  logic [CW-1:0]        qe_in, ke_in, qe_r, ke_r;
  logic [DATAWIDTH-1:0] snap [SIZE*SIZE];
  logic [IW-1:0]        row, col;
  logic                 last;
  logic [XW-1:0]        elem_idx;
  logic                 job_empty, xfer, last_xfer, capture;

  assign qe_in     = (depth_A > CW'(SIZE)) ? CW'(SIZE) : depth_A;
  assign ke_in     = (width_B > CW'(SIZE)) ? CW'(SIZE) : width_B;
  assign job_empty = (qe_in == '0) || (ke_in == '0);
  assign xfer      = (state == DRAIN) && out_if.out_ready;
  assign last_xfer = xfer && last;
  // the array clears dout right after done, so this edge is the only chance to sample it
  assign capture   = done_in && !job_empty && ((state == IDLE) || last_xfer);
  assign elem_idx  = XW'(row) * XW'(SIZE) + XW'(col);

  systolic_drain_idx_counter #(.IW(IW)) u_idx (
    .clk     (clk),
    .rst_n   (reset),
    .load    (capture),
    .advance (xfer),
    .qe      (qe_r),
    .ke      (ke_r),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (last_xfer && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_if.out_valid = (state == DRAIN);
    out_if.out_data  = '0;
    out_if.out_row   = '0;
    out_if.out_col   = '0;
    out_if.out_last  = 1'b0;
    busy             = (state == DRAIN);
    if (state == DRAIN) begin
      out_if.out_data = snap[elem_idx];
      out_if.out_row  = row;
      out_if.out_col  = col;
      out_if.out_last = last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qe_r       <= '0;
      ke_r       <= '0;
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        qe_r <= qe_in;
        ke_r <= ke_in;
      end
      drain_done <= last_xfer || ((state == IDLE) && done_in && job_empty);
      if ((state == DRAIN) && done_in && !last_xfer) overrun <= 1'b1;
      else if (clr_overrun)                          overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < SIZE*SIZE; k++)
        snap[k] <= dout_flat[k*DATAWIDTH +: DATAWIDTH];
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: table of jobs plus hand-written corner sequences.
module tb_systolic_result_drain;

  logic         clk;
  logic         reset;
  logic         done_in;
  logic [2:0]   depth_A;
  logic [2:0]   width_B;
  logic [255:0] dout_flat;
  logic         busy;
  logic         drain_done;
  logic         overrun;
  logic         clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_result_drain_if #(.DATAWIDTH(16), .IW(2)) bus ();

  systolic_result_drain #(.DATAWIDTH(16), .SIZE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .done_in     (done_in),
    .depth_A     (depth_A),
    .width_B     (width_B),
    .dout_flat   (dout_flat),
    .out_if      (bus),
    .busy        (busy),
    .drain_done  (drain_done),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  d;
    logic [2:0]  w;
    int          q;
    int          k;
    logic [15:0] base;
    bit          bp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pat(input logic [15:0] base);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(i*4+j)*16 +: 16] = base + 16'(16*i + j);
    return r;
  endfunction

  task automatic start_job(input logic [2:0] d, input logic [2:0] w, input logic [15:0] base);
    @(negedge clk);
    done_in   = 1'b1;
    depth_A   = d;
    width_B   = w;
    dout_flat = pat(base);
    @(posedge clk);
    #1;
    done_in   = 1'b0;
    dout_flat = '0;
  endtask

  task automatic stream(input int q, input int k, input logic [15:0] base, input bit bp,
                        input int inj_at, input logic [2:0] inj_d, input logic [2:0] inj_w,
                        input logic [15:0] inj_base, input bit skip_wait);
    int beat = 0;
    int cyc = 0;
    bit injected = 0;
    logic [15:0] exp_d;
    while (beat < q*k && cyc < 200) begin
      if (!(skip_wait && cyc == 0)) @(negedge clk);
      exp_d = base + 16'(16*(beat/k) + beat%k);
      check("valid", 32'(bus.out_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("data", 32'(bus.out_data), 32'(exp_d));
      check("row", 32'(bus.out_row), 32'(beat/k));
      check("col", 32'(bus.out_col), 32'(beat%k));
      check("last", 32'(bus.out_last), 32'(beat == q*k-1));
      if (!(skip_wait && cyc == 0)) check("drain_done_low", 32'(drain_done), 32'd0);
      bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (bus.out_ready && beat == inj_at && !injected) begin
        injected  = 1;
        done_in   = 1'b1;
        depth_A   = inj_d;
        width_B   = inj_w;
        dout_flat = pat(inj_base);
      end
      if (bus.out_ready) beat++;
      cyc++;
      @(posedge clk);
      #1;
      done_in   = 1'b0;
      dout_flat = '0;
    end
    bus.out_ready = 1'b1;
    if (beat < q*k) check("stream_timeout", 32'(beat), 32'(q*k));
  endtask

  task automatic post(input bit followon);
    @(negedge clk);
    check("drain_done_pulse", 32'(drain_done), 32'd1);
    check("valid_after", 32'(bus.out_valid), 32'(followon));
    if (!followon) begin
      @(negedge clk);
      check("drain_done_one_cycle", 32'(drain_done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd4, 3'd4, 4, 4, 16'h0000, 1'b0};
    vecs[1] = '{3'd2, 3'd3, 2, 3, 16'h0100, 1'b0};
    vecs[2] = '{3'd4, 3'd4, 4, 4, 16'h0200, 1'b1};
    vecs[3] = '{3'd7, 3'd4, 4, 4, 16'h0300, 1'b0};
    vecs[4] = '{3'd4, 3'd0, 0, 0, 16'h0400, 1'b0};
    vecs[5] = '{3'd0, 3'd2, 0, 0, 16'h0500, 1'b0};
    vecs[6] = '{3'd1, 3'd1, 1, 1, 16'h0600, 1'b0};
    vecs[7] = '{3'd3, 3'd1, 3, 1, 16'h0700, 1'b1};
    vecs[8] = '{3'd1, 3'd4, 1, 4, 16'h0800, 1'b0};
    vecs[9] = '{3'd2, 3'd6, 2, 4, 16'h0900, 1'b1};

    reset         = 1'b0;
    done_in       = 1'b0;
    depth_A       = '0;
    width_B       = '0;
    dout_flat     = '0;
    clr_overrun   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_row_col_last", {29'd0, bus.out_row, bus.out_last}, 32'd0);
    check("rst_col", 32'(bus.out_col), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      start_job(vecs[v].d, vecs[v].w, vecs[v].base);
      if (vecs[v].q * vecs[v].k == 0) begin
        @(negedge clk);
        check("empty_valid", 32'(bus.out_valid), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_drain_done", 32'(drain_done), 32'd1);
        @(negedge clk);
        check("empty_drain_done_one_cycle", 32'(drain_done), 32'd0);
        check("empty_valid_2", 32'(bus.out_valid), 32'd0);
      end else begin
        stream(vecs[v].q, vecs[v].k, vecs[v].base, vecs[v].bp, -1, 3'd0, 3'd0, 16'h0, 1'b0);
        post(1'b0);
      end
    end
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // done_in mid-drain is dropped and flags overrun
    start_job(3'd4, 3'd4, 16'h1000);
    stream(4, 4, 16'h1000, 1'b0, 5, 3'd4, 3'd4, 16'h1F00, 1'b0);
    post(1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // done_in on the final handshake chains a second job
    start_job(3'd2, 3'd3, 16'h2000);
    stream(2, 3, 16'h2000, 1'b0, 5, 3'd3, 3'd2, 16'h3000, 1'b0);
    post(1'b1);
    stream(3, 2, 16'h3000, 1'b0, -1, 3'd0, 3'd0, 16'h0, 1'b1);
    post(1'b0);
    check("chain_no_overrun", 32'(overrun), 32'd0);

    // asynchronous reset mid-drain
    start_job(3'd4, 3'd4, 16'h4000);
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_drain_done", 32'(drain_done), 32'd0);
    start_job(3'd1, 3'd1, 16'h5000);
    stream(1, 1, 16'h5000, 1'b0, -1, 3'd0, 3'd0, 16'h0, 1'b0);
    post(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the 4x4 systolic array top.
- On the array's done pulse it snapshots the full dout matrix into a local buffer, because the array clears its accumulators the cycle after done.
- It then streams only the valid QxK result region, in row-major order, over a valid/ready interface toward the output FIFO/bus adapter.
- It frees the array to start the next job while draining is still in progress.

Parameters:
- DATAWIDTH, 16, width of one result element
- SIZE, 4, array dimension; buffer holds SIZE*SIZE elements

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- done_in  in  1  single-cycle done pulse from the array control
- depth_A  in  $clog2(SIZE)+1  Q, the number of result rows; sampled with done_in
- width_B  in  $clog2(SIZE)+1  K, the number of result columns; sampled with done_in
- dout_flat  in  SIZE*SIZE*DATAWIDTH  array results; element (i,j) at bits [(i*SIZE+j)*DATAWIDTH +: DATAWIDTH]
- out_valid  out  1  out_data/out_row/out_col/out_last are valid
- out_ready  in  1  downstream accepts the current element
- out_data  out  DATAWIDTH  result element
- out_row  out  $clog2(SIZE)  row index i of the current element
- out_col  out  $clog2(SIZE)  column index j of the current element
- out_last  out  1  current element is (Q-1,K-1)
- busy  out  1  a drain is in progress
- drain_done  out  1  one-cycle pulse after the final element transfers, or after an empty job
- overrun  out  1  sticky flag: a done_in arrived while a drain was in progress and was dropped
- clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out_valid, out_last, busy, drain_done and overrun are 0.
  - out_data, out_row and out_col are 0.
  - Buffer contents are don't-care.
- Capture:
  - Occurs on the clk edge where done_in=1 and capture is permitted (see below).
  - dout_flat, depth_A and width_B are registered on that same edge. No later sampling is allowed, because the array clears dout afterward.
  - Qe = min(depth_A, SIZE) and Ke = min(width_B, SIZE). Out-of-range sizes are clamped, not flagged.
- States:
  - IDLE:
    - done_in with Qe>0 and Ke>0: capture, row=0, col=0, go to DRAIN. out_valid rises on the cycle after done_in (latency 1).
    - done_in with Qe=0 or Ke=0: no capture of data, stay in IDLE, drain_done pulses on the next cycle, no output beats.
  - DRAIN:
    - busy=1 and out_valid=1.
    - out_data = buf[row][col]. out_last = (row==Qe-1 && col==Ke-1).
    - A transfer occurs when out_valid && out_ready. One element per cycle is sustained when out_ready is held high.
    - On transfer with col<Ke-1: col++.
    - On transfer with col==Ke-1 and not last: col=0, row++.
    - On the last transfer: go to IDLE; drain_done=1 on the following cycle; out_valid=0 unless a new capture occurred.
    - While out_valid && !out_ready, every out_* signal holds stable.
- Simultaneous events:
  - done_in during DRAIN without a last transfer in the same cycle: the job is dropped, the buffer is untouched, and overrun is set to 1 on the next edge.
  - done_in on the same cycle as the last transfer: the job is accepted as a new capture, state stays DRAIN, row=col=0, and drain_done still pulses for the finished job.
  - clr_overrun and a set condition in the same cycle: set wins.
- Reset mid-drain: the in-flight job is discarded and out_valid drops immediately (asynchronous).
- Ke=1 or Qe=1 are legal. A 1x1 job produces a single beat with out_last=1.

Decomposition:
- A shared package holds:
  - DATAWIDTH and SIZE defaults
  - IDXW = $clog2(SIZE)
  - the state enum {IDLE, DRAIN}
- One sub-module is natural: systolic_drain_idx_counter. It takes Qe, Ke and an advance input, and produces row, col and last. The same counter can be reused by an upstream loader.
- The buffer and FSM stay in the top module.

Test Plan:
- 4x4 job with dout(i,j)=16*i+j and out_ready=1: done_in pulse -> 16 beats on consecutive cycles, data 0,1,2,3,16,...,51; out_last only on beat 16; drain_done one cycle later.
- 2x3 job (depth_A=2, width_B=3): 6 beats carrying (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); elements outside the region are never emitted; out_last on (1,2).
- Backpressure: out_ready toggles 1,0,0,1,... -> out_* stable during stalls, no element skipped or duplicated, 16 beats total.
- dout_flat forced to 0 on the cycle after done_in (models the array clear) -> streamed data equals the values present on the done_in edge.
- done_in during drain -> overrun=1 and the current stream is unaffected. done_in coincident with the last handshake -> a second job streams back-to-back. clr_overrun -> overrun=0.
- width_B=0 -> no out_valid, drain_done pulse one cycle later. depth_A=7 -> clamped to 4 rows. reset=0 asserted mid-drain -> out_valid=0 and busy=0 immediately.
